decade_cntr_sequencer: RTL and testbench

Command-driven controller that drives the control side of a chain of NDIG up/down decade counter digits.
- Control outputs per digit: load, data_in, counter_on, count_up.
- Monitored inputs per digit: count and TC.
- Operation: accepts a BCD preset, a BCD target and a direction; loads the chain, steps it with a ripple enable (digit i steps only when digits 0..i-1 all assert TC), and reports completion when the chain value equals the target.
- Placement: between a host or timer command source and the counter digit instances.

---
 rtl/decade_seq_pkg.sv | 30 +++
 rtl/decade_tick_gen.sv | 28 ++
 rtl/decade_cntr_sequencer.sv | 115 +++++++++++
 tb/tb_decade_cntr_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decade_seq_pkg.sv
// Shared types and BCD helpers for the decade counter sequencer.
package decade_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Widest chain supported; narrower values are zero-padded before checking,
  // and zero nibbles are always legal BCD.
  localparam int MAX_DIG = 4;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  function automatic logic all_bcd(input logic [4*MAX_DIG-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (!is_bcd_digit(v[4*i +: 4])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/decade_tick_gen.sv
// Step-rate prescaler: pulses tick once every TICK_DIV enabled cycles.
module decade_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, wrapping on tick; clr restarts the period.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decade_cntr_sequencer.sv
// Command-driven sequencer for a chain of up/down decade counter digits:
// loads a BCD preset, ripple-steps the chain and reports when it hits target.
module decade_cntr_sequencer
  import decade_seq_pkg::*;
#(
  parameter int NDIG     = 2,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [4*NDIG-1:0] cmd_preset,
  input  logic [4*NDIG-1:0] cmd_target,
  input  logic              abort,
  output logic [NDIG-1:0]   cntr_load,
  output logic [4*NDIG-1:0] cntr_data,
  output logic [NDIG-1:0]   cntr_on,
  output logic              cntr_up,
  input  logic [4*NDIG-1:0] cntr_count,
  input  logic [NDIG-1:0]   cntr_tc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_t state_q, state_d;

  logic [4*NDIG-1:0]    preset_q;
  logic [4*NDIG-1:0]    target_q;
  logic [4*MAX_DIG-1:0] preset_ext;
  logic [4*MAX_DIG-1:0] target_ext;
  logic                 cmd_fire;
  logic                 cmd_ok;
  logic                 match;
  logic                 tick;
  logic                 step;

  assign preset_ext = (4*MAX_DIG)'(cmd_preset);
  assign target_ext = (4*MAX_DIG)'(cmd_target);

  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_ok    = all_bcd(preset_ext) && all_bcd(target_ext);
  assign match     = (cntr_count == target_q);

  // Abort and target match both pre-empt a pending tick in the same cycle.
  assign step = (state_q == RUN) && !abort && !match && tick;

  assign busy      = (state_q == LOAD) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign cntr_load = {NDIG{state_q == LOAD}};
  assign cntr_data = (state_q == LOAD) ? preset_q : '0;

  decade_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == LOAD),
    .en    (state_q == RUN),
    .tick  (tick)
  );

  // Ripple enable: a digit steps only while every lower digit is at its TC.
  always_comb begin
    cntr_on    = '0;
    cntr_on[0] = step;
    for (int i = 1; i < NDIG; i++) begin
      cntr_on[i] = cntr_on[i-1] & cntr_tc[i-1];
    end
  end

  // Next-state selection; abort only matters in LOAD and RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_fire && cmd_ok) state_d = LOAD;
      LOAD: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort)      state_d = IDLE;
        else if (match) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Reject pulse and direction latch; direction persists after the run ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      err     <= 1'b0;
      cntr_up <= 1'b1;
    end else begin
      err <= cmd_fire && !cmd_ok;
      if (cmd_fire && cmd_ok) cntr_up <= cmd_dir;
    end
  end

  // Capture preset and target on an accepted command only.
  always_ff @(posedge clk) begin
    if (cmd_fire && cmd_ok) begin
      preset_q <= cmd_preset;
      target_q <= cmd_target;
    end
  end

endmodule

// File: tb/tb_decade_cntr_sequencer.sv
// Bench for decade_cntr_sequencer: two instances (TICK_DIV 1 and 4) share the
// command stream, each drives its own behavioural two-digit decade chain.
module tb_decade_cntr_sequencer;

  localparam int NDIG = 2;
  localparam int TD [2] = '{1, 4};

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid;
  logic cmd_dir;
  logic [4*NDIG-1:0] cmd_preset;
  logic [4*NDIG-1:0] cmd_target;
  logic abort;

  logic              cmd_ready_a [2];
  logic              busy_a      [2];
  logic              done_a      [2];
  logic              err_a       [2];
  logic              up_a        [2];
  logic [NDIG-1:0]   load_a      [2];
  logic [NDIG-1:0]   on_a        [2];
  logic [NDIG-1:0]   tc_a        [2];
  logic [4*NDIG-1:0] data_a      [2];
  logic [4*NDIG-1:0] count_a     [2];
  logic [3:0]        dig         [2][NDIG];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int done_cnt [2], done_rel [2], steps [2], carries [2];
  int load_cnt [2], err_cnt [2], err_rel [2], acc_cyc [2];
  logic [7:0]      load_data [2];
  logic            load_up   [2];
  logic [NDIG-1:0] load_mask [2];

  always #5 clk = ~clk;

  decade_cntr_sequencer #(.NDIG(NDIG), .TICK_DIV(1)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a[0]),
    .cmd_dir(cmd_dir), .cmd_preset(cmd_preset), .cmd_target(cmd_target),
    .abort(abort), .cntr_load(load_a[0]), .cntr_data(data_a[0]), .cntr_on(on_a[0]),
    .cntr_up(up_a[0]), .cntr_count(count_a[0]), .cntr_tc(tc_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .err(err_a[0])
  );

  decade_cntr_sequencer #(.NDIG(NDIG), .TICK_DIV(4)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a[1]),
    .cmd_dir(cmd_dir), .cmd_preset(cmd_preset), .cmd_target(cmd_target),
    .abort(abort), .cntr_load(load_a[1]), .cntr_data(data_a[1]), .cntr_on(on_a[1]),
    .cntr_up(up_a[1]), .cntr_count(count_a[1]), .cntr_tc(tc_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .err(err_a[1])
  );

  // Behavioural decade digits: count output and combinational TC.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      count_a[k] = '0;
      tc_a[k]    = '0;
      for (int i = 0; i < NDIG; i++) begin
        count_a[k][4*i +: 4] = dig[k][i];
        tc_a[k][i] = up_a[k] ? (dig[k][i] == 4'd9) : (dig[k][i] == 4'd0);
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NDIG; i++) begin
        if (load_a[k][i])
          dig[k][i] <= data_a[k][4*i +: 4];
        else if (on_a[k][i])
          dig[k][i] <= up_a[k] ? ((dig[k][i] == 4'd9) ? 4'd0 : dig[k][i] + 4'd1)
                               : ((dig[k][i] == 4'd0) ? 4'd9 : dig[k][i] - 4'd1);
      end
    end
  end

  // Observe outputs mid-cycle and accumulate per-command statistics.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cmd_valid && cmd_ready_a[k]) acc_cyc[k] = cyc;
      if (|load_a[k]) begin
        load_cnt[k]++;
        load_data[k] = data_a[k];
        load_up[k]   = up_a[k];
        load_mask[k] = load_a[k];
      end
      if (on_a[k][0]) steps[k]++;
      if (on_a[k] == {NDIG{1'b1}}) carries[k]++;
      if (done_a[k]) begin
        done_cnt[k]++;
        done_rel[k] = cyc - acc_cyc[k];
      end
      if (err_a[k]) begin
        err_cnt[k]++;
        err_rel[k] = cyc - acc_cyc[k];
      end
    end
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic int to_int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic int model_steps(input logic dir, input logic [7:0] p, input logic [7:0] t);
    int a, b;
    a = to_int(p);
    b = to_int(t);
    return dir ? (b - a + 100) % 100 : (a - b + 100) % 100;
  endfunction

  // Steps where the ones digit sits at its TC, so the tens digit also moves.
  function automatic int model_carries(input logic dir, input logic [7:0] p, input int n);
    int c, v;
    c = 0;
    for (int j = 0; j < n; j++) begin
      v = dir ? (to_int(p) + j) % 100 : (to_int(p) - j + 200) % 100;
      if ((v % 10) == (dir ? 9 : 0)) c++;
    end
    return c;
  endfunction

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0; done_rel[k] = -1; steps[k] = 0; carries[k] = 0;
      load_cnt[k] = 0; err_cnt[k] = 0; err_rel[k] = -1;
      load_data[k] = 'x; load_up[k] = 1'bx; load_mask[k] = 'x;
    end
  endtask

  // Present one command for exactly one cycle; returns in the cycle after accept.
  task automatic issue(input logic dir, input logic [7:0] pre, input logic [7:0] tgt);
    @(posedge clk); #1;
    clear_stats();
    cmd_valid = 1'b1; cmd_dir = dir; cmd_preset = pre; cmd_target = tgt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic dir, input logic [7:0] pre, input logic [7:0] tgt);
    int n, car;
    n   = model_steps(dir, pre, tgt);
    car = model_carries(dir, pre, n);
    issue(dir, pre, tgt);
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (done_cnt[0] != 0 && done_cnt[1] != 0) break;
    end
    for (int k = 0; k < 2; k++) begin
      chk("done_count", k, done_cnt[k], 1);
      chk("done_cycle", k, done_rel[k], 3 + n * TD[k]);
      chk("step_count", k, steps[k], n);
      chk("carry_steps", k, carries[k], car);
      chk("load_count", k, load_cnt[k], 1);
      chk("load_mask", k, load_mask[k], {NDIG{1'b1}});
      chk("load_data", k, load_data[k], pre);
      chk("load_dir", k, load_up[k], dir);
      chk("final_count", k, count_a[k], tgt);
      chk("idle_after", k, {busy_a[k], cmd_ready_a[k]}, 2'b01);
    end
  endtask

  task automatic run_bad(input logic [7:0] pre, input logic [7:0] tgt);
    issue(1'b1, pre, tgt);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("err_count", k, err_cnt[k], 1);
      chk("err_cycle", k, err_rel[k], 1);
      chk("bad_no_load", k, load_cnt[k], 0);
      chk("bad_idle", k, {busy_a[k], cmd_ready_a[k]}, 2'b01);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_load"}, k, load_a[k], 0);
      chk({tag, "_on"}, k, on_a[k], 0);
      chk({tag, "_data"}, k, data_a[k], 0);
      chk({tag, "_up"}, k, up_a[k], 1);
      chk({tag, "_flags"}, k, {done_a[k], err_a[k], busy_a[k]}, 3'b000);
      chk({tag, "_ready"}, k, cmd_ready_a[k], 1);
    end
  endtask

  initial begin
    logic       dir;
    logic [7:0] pre, tgt;

    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b1;
    cmd_preset = '0; cmd_target = '0; abort = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases from the feature list.
    run_cmd(1'b1, 8'h05, 8'h12);
    run_cmd(1'b1, 8'h95, 8'h03);
    run_cmd(1'b0, 8'h00, 8'h97);
    run_cmd(1'b1, 8'h42, 8'h42);
    run_bad(8'h3A, 8'h10);
    run_bad(8'h10, 8'hF1);

    // Abort on the third RUN cycle of a 20-step run.
    issue(1'b1, 8'h00, 8'h20);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("abort_on", k, on_a[k], 0);
      chk("abort_busy", k, busy_a[k], 1);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("abort_idle", k, {busy_a[k], cmd_ready_a[k]}, 2'b01);
    repeat (30) @(posedge clk);
    for (int k = 0; k < 2; k++) chk("abort_no_done", k, done_cnt[k], 0);
    chk("abort_steps", 0, steps[0], 2);
    chk("abort_steps", 1, steps[1], 0);
    run_cmd(1'b1, 8'h18, 8'h21);

    // Reset in the middle of a down run.
    issue(1'b0, 8'h50, 8'h10);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrun");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("release_ready", k, {busy_a[k], cmd_ready_a[k]}, 2'b01);
    repeat (10) @(posedge clk);
    for (int k = 0; k < 2; k++) chk("reset_no_done", k, done_cnt[k], 0);

    // Randomised legal commands plus a few illegal ones.
    for (int r = 0; r < 8; r++) begin
      dir = 1'($urandom_range(0, 1));
      pre = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      tgt = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_cmd(dir, pre, tgt);
    end
    for (int r = 0; r < 3; r++) begin
      pre = {4'($urandom_range(0, 9)), 4'($urandom_range(10, 15))};
      tgt = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_bad(pre, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
